// File: rtl/stream_mux_lock.sv
// Packet-aware stream multiplexer: selection is locked from the first accepted beat to the last.
// Optional per-packet beat counter enabled by defining STREAM_MUX_LOCK_BEAT_CNT_EN.
module stream_mux_lock #(
  parameter type         DATA_T    = logic,
  parameter int unsigned N_INP     = 2,
  parameter bit          OUP_REG   = 1'b0,
  parameter int unsigned LOG_N_INP = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  DATA_T [N_INP-1:0]    inp_data_i,
  input  logic  [N_INP-1:0]    inp_valid_i,
  input  logic  [N_INP-1:0]    inp_last_i,
  output logic  [N_INP-1:0]    inp_ready_o,
  input  logic  [LOG_N_INP-1:0] inp_sel_i,
  output DATA_T                oup_data_o,
  output logic                 oup_last_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output logic                 lock_o,
  output logic  [LOG_N_INP-1:0] sel_o
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
  ,
  output logic  [15:0]         beat_cnt_o
`endif
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e               state_q, state_d;
  logic [LOG_N_INP-1:0] sel_q, sel_d;
  logic [LOG_N_INP-1:0] sel;
  logic                 sel_in_range;
  logic                 sel_valid;
  logic                 sel_last;
  DATA_T                sel_data;
  logic                 sel_ready;
  logic                 accept;

  // Effective select: the live request while idle, the captured one mid-packet.
  assign sel          = (state_q == StLocked) ? sel_q : inp_sel_i;
  assign sel_in_range = (32'(sel) < N_INP);
  assign sel_o        = sel;
  assign lock_o       = (state_q == StLocked);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    if (sel_in_range) begin
      sel_valid = inp_valid_i[sel];
      sel_last  = inp_last_i[sel];
      sel_data  = inp_data_i[sel];
    end
  end

  always_comb begin
    inp_ready_o = '0;
    if (sel_in_range) begin
      inp_ready_o[sel] = sel_ready;
    end
  end

  assign accept = sel_in_range && sel_valid && sel_ready;

  // Lock follows input-side acceptance only, so the output stage never affects framing.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !sel_last) begin
          state_d = StLocked;
          sel_d   = inp_sel_i;
        end
      end
      StLocked: begin
        if (accept && sel_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  if (OUP_REG) begin : g_oup_reg
    DATA_T data_q;
    logic  last_q;
    logic  full_q;

    // Accepting while full is safe only when the held beat drains this same cycle.
    assign sel_ready = !full_q || oup_ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_q <= '0;
        last_q <= 1'b0;
        full_q <= 1'b0;
      end else if (accept) begin
        data_q <= sel_data;
        last_q <= sel_last;
        full_q <= 1'b1;
      end else if (oup_ready_i) begin
        full_q <= 1'b0;
      end
    end

    assign oup_data_o  = data_q;
    assign oup_last_o  = last_q;
    assign oup_valid_o = full_q;
  end else begin : g_oup_comb
    assign sel_ready   = oup_ready_i;
    assign oup_data_o  = sel_data;
    assign oup_last_o  = sel_last;
    assign oup_valid_o = sel_valid;
  end

`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      if (sel_last) begin
        beat_cnt_d = '0;
      end else if (beat_cnt_q != 16'hFFFF) begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt_o = beat_cnt_q;
`endif

  ready_onehot0: assert property (@(posedge clk_i) $onehot0(inp_ready_o));

endmodule

// File: tb/tb_stream_mux_lock.sv
// Directed bench: combinational 4-input mux driven from a vector table, and a registered
// 3-input mux exercised with hand-written burst, out-of-range and mid-packet reset sequences.
module tb_stream_mux_lock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: four inputs, combinational output path
  logic            rst_a;
  logic [3:0][7:0] a_data;
  logic [3:0]      a_valid, a_last, a_ready;
  logic [1:0]      a_sel, a_selo;
  logic [7:0]      a_odata;
  logic            a_olast, a_ovalid, a_oready, a_lock;
  logic [15:0]     a_cnt;

  // Instance B: three inputs, registered output
  logic            rst_b;
  logic [2:0][7:0] b_data;
  logic [2:0]      b_valid, b_last, b_ready;
  logic [1:0]      b_sel, b_selo;
  logic [7:0]      b_odata;
  logic            b_olast, b_ovalid, b_oready, b_lock;
  logic [15:0]     b_cnt;

  stream_mux_lock #(
    .DATA_T (logic [7:0]),
    .N_INP  (4),
    .OUP_REG(1'b0)
  ) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst_a),
    .inp_data_i (a_data),
    .inp_valid_i(a_valid),
    .inp_last_i (a_last),
    .inp_ready_o(a_ready),
    .inp_sel_i  (a_sel),
    .oup_data_o (a_odata),
    .oup_last_o (a_olast),
    .oup_valid_o(a_ovalid),
    .oup_ready_i(a_oready),
    .lock_o     (a_lock),
    .sel_o      (a_selo)
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
    ,
    .beat_cnt_o (a_cnt)
`endif
  );

  stream_mux_lock #(
    .DATA_T (logic [7:0]),
    .N_INP  (3),
    .OUP_REG(1'b1)
  ) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst_b),
    .inp_data_i (b_data),
    .inp_valid_i(b_valid),
    .inp_last_i (b_last),
    .inp_ready_o(b_ready),
    .inp_sel_i  (b_sel),
    .oup_data_o (b_odata),
    .oup_last_o (b_olast),
    .oup_valid_o(b_ovalid),
    .oup_ready_i(b_oready),
    .lock_o     (b_lock),
    .sel_o      (b_selo)
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
    ,
    .beat_cnt_o (b_cnt)
`endif
  );

`ifndef STREAM_MUX_LOCK_BEAT_CNT_EN
  assign a_cnt = '0;
  assign b_cnt = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        oready;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        ovalid;
    logic        olast;
    logic [7:0]  odata;
    logic        lock;
    logic [1:0]  selo;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin : main
    int idx;
    int rcv;
    logic hold;
    logic [7:0] held;

    // sel, valid, last, oready, d | rdy, ovalid, olast, odata, lock, selo, cnt
    vecs[0]  = '{2'd2, 4'b0110, 4'b0000, 1'b1, 8'h10, 4'b0100, 1'b1, 1'b0, 8'h90, 1'b0, 2'd2, 16'd0};
    vecs[1]  = '{2'd1, 4'b0110, 4'b0000, 1'b1, 8'h11, 4'b0100, 1'b1, 1'b0, 8'h91, 1'b1, 2'd2, 16'd1};
    vecs[2]  = '{2'd1, 4'b0110, 4'b0100, 1'b1, 8'h12, 4'b0100, 1'b1, 1'b1, 8'h92, 1'b1, 2'd2, 16'd2};
    vecs[3]  = '{2'd1, 4'b0010, 4'b0010, 1'b1, 8'h13, 4'b0010, 1'b1, 1'b1, 8'h53, 1'b0, 2'd1, 16'd0};
    vecs[4]  = '{2'd3, 4'b1000, 4'b0000, 1'b0, 8'h20, 4'b0000, 1'b1, 1'b0, 8'hE0, 1'b0, 2'd3, 16'd0};
    vecs[5]  = '{2'd0, 4'b0001, 4'b0001, 1'b1, 8'h21, 4'b0001, 1'b1, 1'b1, 8'h21, 1'b0, 2'd0, 16'd0};
    vecs[6]  = '{2'd3, 4'b1001, 4'b1001, 1'b1, 8'h30, 4'b1000, 1'b1, 1'b1, 8'hF0, 1'b0, 2'd3, 16'd0};
    vecs[7]  = '{2'd0, 4'b1001, 4'b1001, 1'b1, 8'h31, 4'b0001, 1'b1, 1'b1, 8'h31, 1'b0, 2'd0, 16'd0};
    vecs[8]  = '{2'd3, 4'b1001, 4'b1001, 1'b1, 8'h32, 4'b1000, 1'b1, 1'b1, 8'hF2, 1'b0, 2'd3, 16'd0};
    vecs[9]  = '{2'd0, 4'b1001, 4'b1001, 1'b1, 8'h33, 4'b0001, 1'b1, 1'b1, 8'h33, 1'b0, 2'd0, 16'd0};
    vecs[10] = '{2'd1, 4'b0010, 4'b0000, 1'b1, 8'h40, 4'b0010, 1'b1, 1'b0, 8'h80, 1'b0, 2'd1, 16'd0};
    vecs[11] = '{2'd2, 4'b0110, 4'b0000, 1'b0, 8'h41, 4'b0000, 1'b1, 1'b0, 8'h81, 1'b1, 2'd1, 16'd1};
    vecs[12] = '{2'd2, 4'b0010, 4'b0010, 1'b1, 8'h42, 4'b0010, 1'b1, 1'b1, 8'h82, 1'b1, 2'd1, 16'd1};
    vecs[13] = '{2'd2, 4'b0000, 4'b0000, 1'b1, 8'h43, 4'b0100, 1'b0, 1'b0, 8'hC3, 1'b0, 2'd2, 16'd0};

    rst_a = 1'b1; a_data = '0; a_valid = '0; a_last = '0; a_sel = '0; a_oready = 1'b1;
    rst_b = 1'b1; b_data = '0; b_valid = '0; b_last = '0; b_sel = '0; b_oready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    @(negedge clk);
    chk("a_reset_lock", 32'(a_lock), 32'd0);
    chk("a_reset_sel_o", 32'(a_selo), 32'd0);
    chk("b_reset_valid", 32'(b_ovalid), 32'd0);
    chk("b_reset_last", 32'(b_olast), 32'd0);
    chk("b_reset_data", 32'(b_odata), 32'd0);
    chk("b_reset_lock", 32'(b_lock), 32'd0);
    chk("b_reset_sel_o", 32'(b_selo), 32'd0);
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
    chk("b_reset_cnt", 32'(b_cnt), 32'd0);
`endif

    // Table: lock across mid-packet select change, single-beat alternation, backpressure
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      a_sel    = vecs[i].sel;
      a_valid  = vecs[i].valid;
      a_last   = vecs[i].last;
      a_oready = vecs[i].oready;
      for (int j = 0; j < 4; j++) a_data[j] = vecs[i].d + 8'(j * 64);
      @(negedge clk);
      chk($sformatf("a_ready[%0d]", i), 32'(a_ready), 32'(vecs[i].rdy));
      chk($sformatf("a_valid[%0d]", i), 32'(a_ovalid), 32'(vecs[i].ovalid));
      chk($sformatf("a_last[%0d]", i), 32'(a_olast), 32'(vecs[i].olast));
      chk($sformatf("a_data[%0d]", i), 32'(a_odata), 32'(vecs[i].odata));
      chk($sformatf("a_lock[%0d]", i), 32'(a_lock), 32'(vecs[i].lock));
      chk($sformatf("a_sel_o[%0d]", i), 32'(a_selo), 32'(vecs[i].selo));
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
      chk($sformatf("a_cnt[%0d]", i), 32'(a_cnt), 32'(vecs[i].cnt));
`endif
    end
    @(posedge clk);
    #1;
    a_valid = '0;

    // Out-of-range select on the 3-input instance
    b_sel = 2'd3; b_valid = 3'b111; b_last = 3'b000; b_oready = 1'b1;
    @(negedge clk);
    chk("b_oor_ready", 32'(b_ready), 32'd0);
    chk("b_oor_valid", 32'(b_ovalid), 32'd0);
    chk("b_oor_lock", 32'(b_lock), 32'd0);
    chk("b_oor_sel_o", 32'(b_selo), 32'd3);
    @(posedge clk);
    #1;
    chk("b_oor_lock_after", 32'(b_lock), 32'd0);
    chk("b_oor_valid_after", 32'(b_ovalid), 32'd0);
    b_valid = '0;
    b_sel   = 2'd1;

    // 8-beat burst on input 1 through the register, output ready toggling 1010
    idx  = 0;
    rcv  = 0;
    hold = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && (idx < 8 || rcv < 8); c++) begin
      @(posedge clk);
      #1;
      b_oready = (c % 2 == 0);
      b_valid  = '0;
      b_last   = '0;
      if (idx < 8) begin
        b_valid[1] = 1'b1;
        b_data[1]  = 8'h60 + 8'(idx);
        b_last[1]  = (idx == 7);
        b_sel      = (idx > 0) ? 2'd2 : 2'd1;
        if (idx > 0) begin
          b_valid[2] = 1'b1;
          b_data[2]  = 8'hEE;
        end
      end else begin
        b_sel = 2'd1;
      end
      @(negedge clk);
      chk("b_burst_lock", 32'(b_lock), 32'(idx > 0 && idx < 8));
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
      chk("b_burst_cnt", 32'(b_cnt), (idx < 8) ? 32'(idx) : 32'd0);
`endif
      if (idx > 0 && idx < 8) begin
        chk("b_burst_other_ready", {30'd0, b_ready[2], b_ready[0]}, 32'd0);
        chk("b_burst_sel_o", 32'(b_selo), 32'd1);
      end
      if (hold) begin
        chk("b_burst_hold_valid", 32'(b_ovalid), 32'd1);
        chk("b_burst_hold_data", 32'(b_odata), 32'(held));
      end
      if (b_ovalid && b_oready) begin
        chk("b_burst_data", 32'(b_odata), 32'(8'h60 + 8'(rcv)));
        chk("b_burst_last", 32'(b_olast), 32'(rcv == 7));
        rcv++;
      end
      hold = b_ovalid && !b_oready;
      held = 8'h60 + 8'(rcv);
      if (b_valid[1] && b_ready[1]) idx++;
    end
    chk("b_burst_sent", 32'(idx), 32'd8);
    chk("b_burst_rcvd", 32'(rcv), 32'd8);

    // Reset after beat 2 of a 5-beat packet, then a new packet on another input
    @(posedge clk);
    #1;
    b_sel = 2'd0; b_oready = 1'b1; b_valid = 3'b001; b_last = 3'b000; b_data[0] = 8'h70;
    @(posedge clk);
    #1;
    b_data[0] = 8'h71;
    @(posedge clk);
    #1;
    chk("b_rst_pre_lock", 32'(b_lock), 32'd1);
    chk("b_rst_pre_data", 32'(b_odata), 32'h71);
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
    chk("b_rst_pre_cnt", 32'(b_cnt), 32'd2);
`endif
    b_data[0] = 8'h72;
    rst_b     = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    chk("b_rst_lock", 32'(b_lock), 32'd0);
    chk("b_rst_valid", 32'(b_ovalid), 32'd0);
`ifdef STREAM_MUX_LOCK_BEAT_CNT_EN
    chk("b_rst_cnt", 32'(b_cnt), 32'd0);
`endif
    b_sel = 2'd2; b_valid = 3'b100; b_last = 3'b100; b_data[2] = 8'hA5;
    @(negedge clk);
    chk("b_new_ready", 32'(b_ready), 32'b100);
    chk("b_new_sel_o", 32'(b_selo), 32'd2);
    @(posedge clk);
    #1;
    b_valid = '0;
    chk("b_new_valid", 32'(b_ovalid), 32'd1);
    chk("b_new_data", 32'(b_odata), 32'hA5);
    chk("b_new_last", 32'(b_olast), 32'd1);
    chk("b_new_lock", 32'(b_lock), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
